setting_generator: RTL and testbench
====================================

SETTING_GENERATOR -- requirements
Module: setting_generator

Interface
REQ-001 SHALL have parameter SHIFTREG_WIDTH, default 10: NLFSR length N.
REQ-002 SHALL have parameter NUM_NLIN, default 2: number of nonlinear terms.
REQ-003 SHALL have parameter NUM_NLIN_IDX, default 2: indices per nonlinear term.
REQ-004 SHALL derive IDX_W = $clog2(N-1) and SETTING_WIDTH = (N-1) + NUM_NLIN*NUM_NLIN_IDX*IDX_W; these are not overridable.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins enumeration.
- abort  in  1  one-cycle pulse; stops enumeration.
- first_setting  in  SETTING_WIDTH  first candidate, sampled on start.
- max_count  in  32  emission limit, sampled on start; 0 means unlimited.
- fifo_full  in  1  downstream input-FIFO full.
- fifo_din  out  SETTING_WIDTH  candidate setting.
- fifo_wr_en  out  1  write strobe.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- exhausted  out  1  end of space reached.
- num_emitted  out  32  settings written.
- num_skipped  out  32  candidates rejected.

Function
REQ-006 Setting layout SHALL be: bits [N-2:0] linear taps; above them NUM_NLIN*NUM_NLIN_IDX index digits of IDX_W bits each, digit 0 lowest.
REQ-007 Enumeration SHALL be mixed-radix: the linear field counts in binary and wraps at 2^(N-1) with carry; each index digit counts 0..N-2 and wraps to 0 with carry; an index digit >= N-2 SHALL wrap on increment.
REQ-008 A candidate SHALL be canonical iff linear bit 0 = 1, every index digit <= N-2, and the indices within each term are strictly ascending (digit k < digit k+1).
REQ-009 The state machine SHALL have states IDLE, RUN and DONE.
- IDLE -start-> RUN.
- DONE -start-> RUN.
- RUN -abort-> IDLE.
- RUN -limit or exhaustion-> DONE.
REQ-010 start SHALL load the candidate register with first_setting, clear num_emitted, num_skipped and exhausted, and latch max_count; start in RUN SHALL be ignored.
REQ-011 In RUN, one candidate SHALL be processed per cycle, combinationally from registered state:
- canonical and ~fifo_full: fifo_wr_en=1, fifo_din=candidate, num_emitted+1, advance.
- non-canonical: fifo_wr_en=0, num_skipped+1, advance.
- canonical and fifo_full: fifo_wr_en=0, hold; no candidate is dropped or reordered.
REQ-012 fifo_wr_en SHALL be 0 outside RUN and in any cycle with abort=1; abort has priority over the write.
REQ-013 The first candidate SHALL be evaluated in the cycle after the start pulse.
REQ-014 When a write makes num_emitted equal a nonzero max_count, the next state SHALL be DONE with exhausted=0.
REQ-015 When the all-maximum candidate (linear all ones, every digit N-2) is processed (written or skipped), the next state SHALL be DONE with exhausted=1; if this coincides with REQ-014, exhausted=1.
REQ-016 Counters SHALL saturate at 2^32-1.
REQ-017 fifo_din SHALL equal the candidate register in every state.

Reset
REQ-018 Asserting reset SHALL immediately force IDLE, fifo_wr_en=0, busy=0, done=0, exhausted=0, both counters 0, and candidate and fifo_din 0, including mid-RUN.

Structure
REQ-019 SETTING_WIDTH/IDX_W derivation functions and state encodings SHALL live in the shared package nlfsr_pkg.
REQ-020 The canonical check SHALL be a combinational sub-module setting_canon_check.

Verification (N=4, NUM_NLIN=1, NUM_NLIN_IDX=2 -> SETTING_WIDTH=7)
REQ-021 start with first_setting=0, max_count=0, fifo_full=0 -> writes 0x21 first; 12 writes total; num_skipped=60; DONE; exhausted=1; last candidate 0x57.
REQ-022 start with first_setting=0, max_count=3 -> writes 0x21, 0x23, 0x25 in order; DONE; exhausted=0.
REQ-023 fifo_full high for 5 cycles while candidate 0x23 is pending -> no write for those 5 cycles; 0x23 is written the cycle full drops; sequence unchanged.
REQ-024 abort after the second write -> IDLE next cycle; no write in the abort cycle; num_emitted=2; a later start reloads and clears the counters.
REQ-025 start with first_setting=0x57 -> 1 skip; DONE; exhausted=1; num_emitted=0.
REQ-026 reset asserted mid-RUN without a clock edge -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/nlfsr_pkg.sv
// Shared definitions for the NLFSR setting enumerator: width derivations,
// generator state encoding and a saturating counter helper.
package nlfsr_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gen_state_e;

    // Width of one nonlinear index digit for an N-bit register.
    function automatic int unsigned calc_idx_w(input int unsigned n);
        return $clog2(n - 1);
    endfunction

    // Linear tap field plus every nonlinear index digit.
    function automatic int unsigned calc_setting_width(input int unsigned n,
                                                       input int unsigned num_nlin,
                                                       input int unsigned num_idx);
        return (n - 1) + num_nlin * num_idx * calc_idx_w(n);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/setting_canon_check.sv
// Combinational classification of one candidate setting: canonical form and
// the all-maximum (last) point of the enumeration space.
module setting_canon_check
    import nlfsr_pkg::*;
#(
    parameter  int unsigned SHIFTREG_WIDTH = 10,
    parameter  int unsigned NUM_NLIN       = 2,
    parameter  int unsigned NUM_NLIN_IDX   = 2,
    localparam int unsigned IDX_W          = calc_idx_w(SHIFTREG_WIDTH),
    localparam int unsigned SETTING_WIDTH  = calc_setting_width(SHIFTREG_WIDTH, NUM_NLIN, NUM_NLIN_IDX)
) (
    input  logic [SETTING_WIDTH-1:0] setting,
    output logic                     canonical_c,
    output logic                     all_max_c
);

    localparam int unsigned LIN_W   = SHIFTREG_WIDTH - 1;
    localparam int unsigned NUM_DIG = NUM_NLIN * NUM_NLIN_IDX;
    localparam logic [IDX_W-1:0] DIG_MAX = IDX_W'(SHIFTREG_WIDTH - 2);

    logic [IDX_W-1:0] dig_c;
    logic [IDX_W-1:0] lo_c;
    logic [IDX_W-1:0] hi_c;

    always_comb begin
        canonical_c = setting[0];
        all_max_c   = &setting[LIN_W-1:0];
        dig_c       = '0;
        lo_c        = '0;
        hi_c        = '0;
        for (int unsigned d = 0; d < NUM_DIG; d++) begin
            dig_c = setting[LIN_W + d*IDX_W +: IDX_W];
            if (dig_c > DIG_MAX) begin
                canonical_c = 1'b0;
            end
            if (dig_c != DIG_MAX) begin
                all_max_c = 1'b0;
            end
        end
        // Indices inside a term must be strictly ascending to avoid duplicate products.
        for (int unsigned t = 0; t < NUM_NLIN; t++) begin
            for (int unsigned k = 0; k + 1 < NUM_NLIN_IDX; k++) begin
                lo_c = setting[LIN_W + (t*NUM_NLIN_IDX + k)*IDX_W +: IDX_W];
                hi_c = setting[LIN_W + (t*NUM_NLIN_IDX + k + 1)*IDX_W +: IDX_W];
                if (lo_c >= hi_c) begin
                    canonical_c = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/setting_generator.sv
// Enumerates NLFSR feedback settings in mixed-radix order and streams the
// canonical ones into a downstream FIFO, one candidate per cycle.
module setting_generator
    import nlfsr_pkg::*;
#(
    parameter  int unsigned SHIFTREG_WIDTH = 10,
    parameter  int unsigned NUM_NLIN       = 2,
    parameter  int unsigned NUM_NLIN_IDX   = 2,
    localparam int unsigned IDX_W          = calc_idx_w(SHIFTREG_WIDTH),
    localparam int unsigned SETTING_WIDTH  = calc_setting_width(SHIFTREG_WIDTH, NUM_NLIN, NUM_NLIN_IDX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SETTING_WIDTH-1:0] first_setting,
    input  logic [CNT_W-1:0]         max_count,
    input  logic                     fifo_full,
    output logic [SETTING_WIDTH-1:0] fifo_din,
    output logic                     fifo_wr_en,
    output logic                     busy,
    output logic                     done,
    output logic                     exhausted,
    output logic [CNT_W-1:0]         num_emitted,
    output logic [CNT_W-1:0]         num_skipped
);

    localparam int unsigned LIN_W   = SHIFTREG_WIDTH - 1;
    localparam int unsigned NUM_DIG = NUM_NLIN * NUM_NLIN_IDX;
    localparam logic [IDX_W-1:0] DIG_MAX = IDX_W'(SHIFTREG_WIDTH - 2);

    gen_state_e               state_q, state_d;
    logic [SETTING_WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]         emitted_q, emitted_d;
    logic [CNT_W-1:0]         skipped_q, skipped_d;
    logic [CNT_W-1:0]         max_q, max_d;
    logic                     exhausted_q, exhausted_d;
    logic                     wr_c;

    logic                     canonical_c;
    logic                     all_max_c;
    logic [SETTING_WIDTH-1:0] cand_next_c;
    logic [IDX_W-1:0]         dig_c;
    logic                     carry_c;

    setting_canon_check #(
        .SHIFTREG_WIDTH (SHIFTREG_WIDTH),
        .NUM_NLIN       (NUM_NLIN),
        .NUM_NLIN_IDX   (NUM_NLIN_IDX)
    ) u_canon (
        .setting     (cand_q),
        .canonical_c (canonical_c),
        .all_max_c   (all_max_c)
    );

    // Mixed-radix successor: binary linear field, then base-(N-1) digits.
    always_comb begin
        cand_next_c = cand_q;
        {carry_c, cand_next_c[LIN_W-1:0]} = {1'b0, cand_q[LIN_W-1:0]} + (LIN_W + 1)'(1);
        dig_c = '0;
        for (int unsigned d = 0; d < NUM_DIG; d++) begin
            dig_c = cand_q[LIN_W + d*IDX_W +: IDX_W];
            if (carry_c) begin
                if (dig_c >= DIG_MAX) begin
                    dig_c = '0;
                end else begin
                    dig_c   = dig_c + IDX_W'(1);
                    carry_c = 1'b0;
                end
            end
            cand_next_c[LIN_W + d*IDX_W +: IDX_W] = dig_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            emitted_q   <= '0;
            skipped_q   <= '0;
            max_q       <= '0;
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            emitted_q   <= emitted_d;
            skipped_q   <= skipped_d;
            max_q       <= max_d;
            exhausted_q <= exhausted_d;
        end
    end

    // Candidate stays on the last processed value when the run finishes.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        emitted_d   = emitted_q;
        skipped_d   = skipped_q;
        max_d       = max_q;
        exhausted_d = exhausted_q;
        wr_c        = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cand_d      = first_setting;
                    emitted_d   = '0;
                    skipped_d   = '0;
                    max_d       = max_count;
                    exhausted_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (canonical_c && !fifo_full) begin
                    wr_c      = 1'b1;
                    emitted_d = sat_inc(emitted_q);
                    if (all_max_c) begin
                        state_d     = ST_DONE;
                        exhausted_d = 1'b1;
                    end else if (max_q != '0 && emitted_d == max_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cand_d = cand_next_c;
                    end
                end else if (!canonical_c) begin
                    skipped_d = sat_inc(skipped_q);
                    if (all_max_c) begin
                        state_d     = ST_DONE;
                        exhausted_d = 1'b1;
                    end else begin
                        cand_d = cand_next_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo_din    = cand_q;
    assign fifo_wr_en  = wr_c;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign exhausted   = exhausted_q;
    assign num_emitted = emitted_q;
    assign num_skipped = skipped_q;

endmodule

// File: tb/tb_setting_generator.sv
// Randomized bench for setting_generator (N=4, one 2-index term) against an
// ordered list of the whole enumeration space.
module tb_setting_generator;

    logic        clk_fast = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [6:0]  first_setting;
    logic [31:0] max_count;
    logic        fifo_full;
    logic [6:0]  fifo_din;
    logic        fifo_wr_en;
    logic        busy;
    logic        done;
    logic        exhausted;
    logic [31:0] num_emitted;
    logic [31:0] num_skipped;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] space_q[$];
    logic [6:0] got_q[$];
    logic [6:0] exp_q[$];
    int         exp_skip;
    bit         exp_exh;
    logic [6:0] exp_last;

    always #5 clk_fast = ~clk_fast;

    setting_generator #(
        .SHIFTREG_WIDTH (4),
        .NUM_NLIN       (1),
        .NUM_NLIN_IDX   (2)
    ) dut (
        .clk           (clk_fast),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .first_setting (first_setting),
        .max_count     (max_count),
        .fifo_full     (fifo_full),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .busy          (busy),
        .done          (done),
        .exhausted     (exhausted),
        .num_emitted   (num_emitted),
        .num_skipped   (num_skipped)
    );

    // Enumeration order: d1 outermost, then d0, then the 3-bit linear field.
    task automatic build_space();
        space_q.delete();
        for (int d1 = 0; d1 < 3; d1++)
            for (int d0 = 0; d0 < 3; d0++)
                for (int lin = 0; lin < 8; lin++)
                    space_q.push_back(7'(d1 * 32 + d0 * 8 + lin));
    endtask

    function automatic bit model_canon(input logic [6:0] c);
        int lin, d0, d1;
        lin = int'(c) % 8;
        d0  = (int'(c) / 8) % 4;
        d1  = int'(c) / 32;
        return (lin % 2 == 1) && d0 <= 2 && d1 <= 2 && d0 < d1;
    endfunction

    task automatic build_expect(input int idx, input logic [31:0] maxc);
        exp_q.delete();
        exp_skip = 0;
        exp_exh  = 0;
        exp_last = '0;
        for (int i = idx; i < space_q.size(); i++) begin
            exp_last = space_q[i];
            if (model_canon(space_q[i])) exp_q.push_back(space_q[i]);
            else exp_skip++;
            if (i == space_q.size() - 1) begin
                exp_exh = 1;
                break;
            end
            if (model_canon(space_q[i]) && maxc != 0 && 32'(exp_q.size()) == maxc) break;
        end
    endtask

    // Starts a run, applies random backpressure and records every write.
    task automatic run_collect(input logic [6:0] first, input logic [31:0] maxc,
                               input int full_pct, input bit restart_mid,
                               output bit timed_out);
        got_q.delete();
        @(negedge clk_fast);
        start = 1'b1; first_setting = first; max_count = maxc; fifo_full = 1'b0;
        @(negedge clk_fast);
        start = 1'b0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            fifo_full = ($urandom_range(99, 0) < full_pct);
            if (restart_mid && cyc == 3) begin
                start = 1'b1; first_setting = 7'($urandom); max_count = 32'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (fifo_wr_en) got_q.push_back(fifo_din);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk_fast);
        end
        start = 1'b0; fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk_fast); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        n_checks++; if (num_emitted !== 32'd0 || num_skipped !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", num_emitted, num_skipped); end
        n_checks++; if (fifo_din !== 7'h00 || exhausted !== 1'b0) begin n_fail++; $display("FAIL reset_din_exh: got %h/%b want 00/0", fifo_din, exhausted); end
        reset = 1'b0;
        @(negedge clk_fast); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_full_run();
        bit to;
        run_collect(7'h00, 32'd0, 0, 0, to);
        build_expect(0, 32'd0);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: run did not finish"); end
        n_checks++; if (got_q.size() != 12 || exp_q.size() != 12) begin n_fail++; $display("FAIL full_count: got %0d want 12", got_q.size()); end
        n_checks++; if (got_q.size() == 0 || got_q[0] !== 7'h21) begin n_fail++; $display("FAIL full_first: got %h want 21", got_q.size() ? got_q[0] : 7'hxx); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_seq[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (num_skipped !== 32'd60 || num_emitted !== 32'd12) begin n_fail++; $display("FAIL full_counters: got %0d/%0d want 12/60", num_emitted, num_skipped); end
        n_checks++; if (done !== 1'b1 || exhausted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_status: got done=%b exh=%b busy=%b want 1/1/0", done, exhausted, busy); end
        n_checks++; if (fifo_din !== 7'h57 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL full_last: got din=%h wr=%b want 57/0", fifo_din, fifo_wr_en); end
    endtask

    task automatic test_limit();
        bit to;
        logic [6:0] want [3];
        want[0] = 7'h21; want[1] = 7'h23; want[2] = 7'h25;
        run_collect(7'h00, 32'd3, 0, 0, to);
        build_expect(0, 32'd3);
        n_checks++; if (to !== 1'b0 || got_q.size() != 3) begin n_fail++; $display("FAIL limit_count: got %0d writes timeout=%b want 3", got_q.size(), to); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL limit_seq[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
        n_checks++; if (done !== 1'b1 || exhausted !== 1'b0) begin n_fail++; $display("FAIL limit_status: got done=%b exh=%b want 1/0", done, exhausted); end
        n_checks++; if (num_emitted !== 32'd3 || num_skipped !== 32'(exp_skip)) begin n_fail++; $display("FAIL limit_counters: got %0d/%0d want 3/%0d", num_emitted, num_skipped, exp_skip); end
    endtask

    task automatic test_fifo_full();
        bit held = 0;
        bit fin  = 0;
        got_q.delete();
        @(negedge clk_fast);
        start = 1'b1; first_setting = 7'h00; max_count = 32'd0; fifo_full = 1'b0;
        @(negedge clk_fast);
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            fifo_full = 1'b0;
            #1;
            if (!held && busy && fifo_din === 7'h23) begin
                for (int k = 0; k < 5; k++) begin
                    fifo_full = 1'b1; #1;
                    n_checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 7'h23) begin n_fail++; $display("FAIL full_hold[%0d]: got wr=%b din=%h want 0/23", k, fifo_wr_en, fifo_din); end
                    @(negedge clk_fast);
                end
                fifo_full = 1'b0; #1;
                n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 7'h23) begin n_fail++; $display("FAIL full_release: got wr=%b din=%h want 1/23", fifo_wr_en, fifo_din); end
                held = 1;
            end
            if (fifo_wr_en) got_q.push_back(fifo_din);
            if (!busy) begin
                fin = 1;
                break;
            end
            @(negedge clk_fast);
        end
        build_expect(0, 32'd0);
        n_checks++; if (!held || !fin) begin n_fail++; $display("FAIL full_reach: got held=%b finished=%b want 1/1", held, fin); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_bp_seq[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        @(negedge clk_fast);
        start = 1'b1; first_setting = 7'h00; max_count = 32'd0; fifo_full = 1'b0;
        @(negedge clk_fast);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            #1;
            if (busy && num_emitted === 32'd2 && fifo_wr_en) begin
                abort = 1'b1; #1;
                n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_wr: got %b want 0", fifo_wr_en); end
                seen = 1;
                @(negedge clk_fast);
                abort = 1'b0; #1;
                n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b done=%b want 0/0", busy, done); end
                n_checks++; if (num_emitted !== 32'd2) begin n_fail++; $display("FAIL abort_emitted: got %0d want 2", num_emitted); end
            end else begin
                @(negedge clk_fast);
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_reach: got no third pending write want one"); end
        @(negedge clk_fast);
        start = 1'b1; first_setting = 7'h21; max_count = 32'd1;
        @(negedge clk_fast);
        start = 1'b0; #1;
        n_checks++; if (num_emitted !== 32'd0 || num_skipped !== 32'd0 || busy !== 1'b1 || fifo_din !== 7'h21) begin n_fail++; $display("FAIL abort_restart: got em=%0d sk=%0d busy=%b din=%h want 0/0/1/21", num_emitted, num_skipped, busy, fifo_din); end
        @(negedge clk_fast); #1;
        n_checks++; if (done !== 1'b1 || num_emitted !== 32'd1 || exhausted !== 1'b0) begin n_fail++; $display("FAIL abort_rerun: got done=%b em=%0d exh=%b want 1/1/0", done, num_emitted, exhausted); end
    endtask

    task automatic test_last_candidate();
        @(negedge clk_fast);
        start = 1'b1; first_setting = 7'h57; max_count = 32'd0;
        @(negedge clk_fast);
        start = 1'b0; #1;
        n_checks++; if (busy !== 1'b1 || fifo_din !== 7'h57 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL last_eval: got busy=%b din=%h wr=%b want 1/57/0", busy, fifo_din, fifo_wr_en); end
        @(negedge clk_fast); #1;
        n_checks++; if (done !== 1'b1 || exhausted !== 1'b1) begin n_fail++; $display("FAIL last_status: got done=%b exh=%b want 1/1", done, exhausted); end
        n_checks++; if (num_skipped !== 32'd1 || num_emitted !== 32'd0) begin n_fail++; $display("FAIL last_counters: got em=%0d sk=%0d want 0/1", num_emitted, num_skipped); end
    endtask

    task automatic test_back_to_back();
        bit to;
        run_collect(space_q[5], 32'd0, 20, 1, to);
        build_expect(5, 32'd0);
        n_checks++; if (to !== 1'b0 || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_ignore_count: got %0d timeout=%b want %0d", got_q.size(), to, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_ignore_seq[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        run_collect(space_q[60], 32'd2, 0, 0, to);
        build_expect(60, 32'd2);
        n_checks++; if (to !== 1'b0 || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n_checks++; if (num_skipped !== 32'(exp_skip) || exhausted !== 1'(exp_exh)) begin n_fail++; $display("FAIL b2b_status: got sk=%0d exh=%b want %0d/%b", num_skipped, exhausted, exp_skip, exp_exh); end
    endtask

    task automatic test_random();
        bit to;
        int idx;
        logic [31:0] maxc;
        for (int it = 0; it < 8; it++) begin
            idx  = int'($urandom_range(71, 0));
            maxc = 32'($urandom_range(5, 0));
            run_collect(space_q[idx], maxc, int'($urandom_range(60, 0)), 0, to);
            build_expect(idx, maxc);
            n_checks++; if (to !== 1'b0 || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d timeout=%b want %0d", it, got_q.size(), to, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_seq[%0d]: got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            n_checks++; if (num_emitted !== 32'(exp_q.size()) || num_skipped !== 32'(exp_skip)) begin n_fail++; $display("FAIL rand%0d_counters: got %0d/%0d want %0d/%0d", it, num_emitted, num_skipped, exp_q.size(), exp_skip); end
            n_checks++; if (done !== 1'b1 || exhausted !== 1'(exp_exh) || fifo_din !== exp_last) begin n_fail++; $display("FAIL rand%0d_end: got done=%b exh=%b din=%h want 1/%b/%h", it, done, exhausted, fifo_din, exp_exh, exp_last); end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk_fast);
        start = 1'b1; first_setting = 7'h00; max_count = 32'd0; fifo_full = 1'b0;
        @(negedge clk_fast);
        start = 1'b0;
        repeat (30) @(negedge clk_fast);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || fifo_wr_en !== 1'b0 || exhausted !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got busy=%b done=%b wr=%b exh=%b want 0", busy, done, fifo_wr_en, exhausted); end
        n_checks++; if (num_emitted !== 32'd0 || num_skipped !== 32'd0 || fifo_din !== 7'h00) begin n_fail++; $display("FAIL midreset_data: got em=%0d sk=%0d din=%h want 0/0/00", num_emitted, num_skipped, fifo_din); end
        @(negedge clk_fast);
        reset = 1'b0;
        @(negedge clk_fast); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy=%b done=%b wr=%b want 0/0/0", busy, done, fifo_wr_en); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_setting = '0; max_count = '0; fifo_full = 1'b0;
        build_space();
        test_reset();
        test_full_run();
        test_limit();
        test_fifo_full();
        test_abort();
        test_last_candidate();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
